// File: rtl/data_mem_pkg.sv
// Shared types and default sizing for the synchronous data memory block.
// The FSM state type lives here so the top and any future siblings agree on encoding.
package data_mem_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEPTH  = 32;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        RESP  = 2'd2
    } memState_e;

endpackage

// File: rtl/data_mem_array.sv
// Single-port word RAM with per-byte write mask and a registered read port.
// Holds no reset on purpose; only the controller's CLEAR pass zeroes it.
module data_mem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = 5
) (
    input  logic                  clk,
    input  logic                  readEn,
    input  logic                  writeEn,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_W/8-1:0]   byteEn,
    input  logic [DATA_W-1:0]     wData,
    output logic [DATA_W-1:0]     rdData
);

    localparam int NUM_BYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // The read output only moves on a read strobe, so it stays stable through RESP.
    always_ff @(posedge clk) begin
        if (writeEn) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (byteEn[b]) begin
                    mem[idx][8*b +: 8] <= wData[8*b +: 8];
                end
            end
        end
        if (readEn) begin
            rdData <= mem[idx];
        end
    end

endmodule

// File: rtl/data_mem_sync.sv
// Request/response controller around data_mem_array: post-reset clear, handshake,
// one read in flight, and error pulses for bad addresses or read+write collisions.
module data_mem_sync
    import data_mem_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wData,
    input  logic [DATA_W/8-1:0]   byte_en,
    output logic [DATA_W-1:0]     rData,
    output logic                  rvalid,
    output logic                  err,
    output logic                  init_done
);

    localparam int NUM_BYTES = DATA_W / 8;
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam memState_e         RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

    memState_e               state;
    memState_e               nextState;
    logic [IDX_W-1:0]        clearIdx;
    logic                    initDone;
    logic                    initDoneNext;
    logic                    respOob;
    logic [DATA_W-1:0]       rDataHold;
    logic                    accept;
    logic                    inRange;
    logic                    errNext;
    logic                    ramRe;
    logic                    ramWe;
    logic [IDX_W-1:0]        ramIdx;
    logic [NUM_BYTES-1:0]    ramBe;
    logic [DATA_W-1:0]       ramWData;
    logic [DATA_W-1:0]       ramQ;

    assign inRange   = ({1'b0, addr} < DEPTH_L);
    assign req_ready = (state == IDLE) && initDone;
    assign accept    = req_valid && req_ready;
    assign rvalid    = (state == RESP);
    assign init_done = initDone;
    // During RESP the fresh RAM word is shown directly; afterwards the held copy keeps it stable.
    assign rData     = (state == RESP) ? (respOob ? '0 : ramQ) : rDataHold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_STATE;
        end else begin
            state <= nextState;
        end
    end

    // Next state plus steering of the single RAM port between the clear pass and requests.
    always_comb begin
        nextState    = state;
        initDoneNext = initDone;
        ramRe        = 1'b0;
        ramWe        = 1'b0;
        ramIdx       = addr[IDX_W-1:0];
        ramBe        = byte_en;
        ramWData     = wData;
        errNext      = accept && ((MemRead && MemWrite) || ((MemRead || MemWrite) && !inRange));
        case (state)
            CLEAR: begin
                ramWe    = 1'b1;
                ramIdx   = clearIdx;
                ramBe    = '1;
                ramWData = '0;
                if (clearIdx == LAST_IDX) begin
                    nextState    = IDLE;
                    initDoneNext = 1'b1;
                end
            end
            IDLE: begin
                initDoneNext = 1'b1;
                if (accept && MemRead) begin
                    nextState = RESP;
                    ramRe     = inRange;
                end else if (accept && MemWrite && inRange) begin
                    ramWe = 1'b1;
                end
            end
            RESP: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clearIdx  <= '0;
            initDone  <= 1'b0;
            err       <= 1'b0;
            respOob   <= 1'b0;
            rDataHold <= '0;
        end else begin
            err      <= errNext;
            initDone <= initDoneNext;
            if ((state == CLEAR) && (clearIdx != LAST_IDX)) begin
                clearIdx <= clearIdx + IDX_W'(1);
            end
            if ((state == IDLE) && accept && MemRead) begin
                respOob <= !inRange;
            end
            if (state == RESP) begin
                rDataHold <= rData;
            end
        end
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) uArray (
        .clk     (clk),
        .readEn  (ramRe),
        .writeEn (ramWe),
        .idx     (ramIdx),
        .byteEn  (ramBe),
        .wData   (ramWData),
        .rdData  (ramQ)
    );

endmodule

// File: tb/tb_data_mem_sync.sv
// Directed bench for data_mem_sync at default parameters; expected values are hand-computed.
module tb_data_mem_sync;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [7:0]  addr = '0;
    logic [15:0] wData = '0;
    logic [1:0]  byte_en = '0;
    logic [15:0] rData;
    logic        rvalid;
    logic        err;
    logic        init_done;

    int checks = 0;
    int failures = 0;
    int cycles;
    int pulses;

    always #5 clk = ~clk;

    data_mem_sync dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .addr      (addr),
        .wData     (wData),
        .byte_en   (byte_en),
        .rData     (rData),
        .rvalid    (rvalid),
        .err       (err),
        .init_done (init_done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of request inputs, then returns #1 after the edge with inputs idle.
    task automatic applyStimulus(input logic v, input logic rd, input logic wr, input logic [7:0] a,
                                 input logic [15:0] wd, input logic [1:0] be);
        req_valid = v;
        MemRead   = rd;
        MemWrite  = wr;
        addr      = a;
        wData     = wd;
        byte_en   = be;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
    endtask

    task automatic waitInit(output int nCycles, output int nPulses);
        nCycles = 0;
        nPulses = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (rvalid) nPulses++;
            if (init_done) begin
                nCycles = i;
                break;
            end
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_rvalid", 32'(rvalid), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_rdata", 32'(rData), 32'd0);
        checkOutput("reset_init_done", 32'(init_done), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        waitInit(cycles, pulses);
        checkOutput("init_cycles", 32'(cycles), 32'd32);
        checkOutput("init_ready", 32'(req_ready), 32'd1);

        applyStimulus(1'b1, 1'b1, 1'b0, 8'd5, 16'h0, 2'b00);
        checkOutput("rd5_rvalid", 32'(rvalid), 32'd1);
        checkOutput("rd5_rdata", 32'(rData), 32'h0000);
        checkOutput("rd5_ready_busy", 32'(req_ready), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 2'b00);
        checkOutput("rd5_rvalid_drop", 32'(rvalid), 32'd0);

        applyStimulus(1'b1, 1'b0, 1'b1, 8'd3, 16'hBEEF, 2'b11);
        checkOutput("wr3_err", 32'(err), 32'd0);
        checkOutput("wr3_ready", 32'(req_ready), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd3, 16'h0, 2'b00);
        checkOutput("rd3_full", 32'(rData), 32'hBEEF);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 2'b00);
        checkOutput("rd3_hold", 32'(rData), 32'hBEEF);

        applyStimulus(1'b1, 1'b0, 1'b1, 8'd3, 16'h1234, 2'b01);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd3, 16'h0, 2'b00);
        checkOutput("rd3_lowbyte", 32'(rData), 32'hBE34);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 2'b00);

        applyStimulus(1'b1, 1'b0, 1'b1, 8'd7, 16'h00AA, 2'b11);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd7, 16'h5555, 2'b11);
        checkOutput("rw7_rdata", 32'(rData), 32'h00AA);
        checkOutput("rw7_err", 32'(err), 32'd1);
        checkOutput("rw7_rvalid", 32'(rvalid), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 2'b00);
        checkOutput("rw7_err_drop", 32'(err), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd7, 16'h0, 2'b00);
        checkOutput("rd7_unchanged", 32'(rData), 32'h00AA);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 2'b00);

        applyStimulus(1'b1, 1'b1, 1'b0, 8'd40, 16'h0, 2'b00);
        checkOutput("rd40_rdata", 32'(rData), 32'h0000);
        checkOutput("rd40_rvalid", 32'(rvalid), 32'd1);
        checkOutput("rd40_err", 32'(err), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 2'b00);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd40, 16'hFFFF, 2'b11);
        checkOutput("wr40_err", 32'(err), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd8, 16'h0, 2'b00);
        checkOutput("rd8_alias_clean", 32'(rData), 32'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 2'b00);

        applyStimulus(1'b1, 1'b0, 1'b1, 8'd3, 16'hFFFF, 2'b00);
        checkOutput("wr3_nomask_err", 32'(err), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd3, 16'h0, 2'b00);
        checkOutput("rd3_nomask", 32'(rData), 32'hBE34);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 2'b00);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'd50, 16'h0, 2'b11);
        checkOutput("noop_err", 32'(err), 32'd0);
        checkOutput("noop_rvalid", 32'(rvalid), 32'd0);
        checkOutput("noop_ready", 32'(req_ready), 32'd1);

        // Back-to-back reads with req_valid held high.
        req_valid = 1'b1;
        MemRead   = 1'b1;
        addr      = 8'd7;
        pulses    = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (rvalid) pulses++;
            checkOutput($sformatf("b2b_ready_%0d", i), 32'(req_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        req_valid = 1'b0;
        MemRead   = 1'b0;
        checkOutput("b2b_rvalid_count", 32'(pulses), 32'd2);

        // Reset lands right on the edge that accepts a read.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd3, 16'h7777, 2'b11);
        req_valid = 1'b1;
        MemRead   = 1'b1;
        addr      = 8'd3;
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        req_valid = 1'b0;
        MemRead   = 1'b0;
        checkOutput("rstmid_rvalid", 32'(rvalid), 32'd0);
        checkOutput("rstmid_ready", 32'(req_ready), 32'd0);
        checkOutput("rstmid_init_done", 32'(init_done), 32'd0);
        checkOutput("rstmid_rdata", 32'(rData), 32'h0000);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        waitInit(cycles, pulses);
        checkOutput("reinit_cycles", 32'(cycles), 32'd32);
        checkOutput("reinit_no_rvalid", 32'(pulses), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd3, 16'h0, 2'b00);
        checkOutput("reinit_rd3_cleared", 32'(rData), 32'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 16'h0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
